muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, beside the ALU.
- Consumes the same A/B operands and Sign control that the ALU receives from the register file and control unit.
- Owns the HI/LO architectural registers. Their outputs are read through the same writeback mux as the ALU's Z for mfhi/mflo.
- Serves mult/multu/div/divu/mthi/mtlo. A start/busy handshake lets control stall the pipeline.

Parameters:
WIDTH, 32, operand and HI/LO width.
ITER, WIDTH, iteration cycles per mult/div; fixed equal to WIDTH.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
A  input  WIDTH  operand 1 (rs): multiplicand / dividend / mthi-mtlo data
B  input  WIDTH  operand 2 (rt): multiplier / divisor
Sign  input  1  1 = signed (two's complement), 0 = unsigned; same meaning as the ALU's Sign
Op  input  2  00 mult, 01 div, 10 mthi, 11 mtlo
Start  input  1  request; sampled on the rising edge only when Busy=0
Busy  output  1  1 while a mult/div is in flight
Done  output  1  one-cycle pulse when new mult/div results land in HI/LO
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; Busy=0, Done=0, Hi=0, Lo=0; iteration counter=0; operand and sign latches cleared.
  - Reset mid-operation aborts with no partial HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - Start=1 with Op=10: Hi<=A at that edge. Single cycle; no Busy, no Done.
  - Start=1 with Op=11: Lo<=A at that edge. Single cycle; no Busy, no Done.
  - Start=1 with Op=00 or 01: latch magnitudes.
    - If Sign=1, use |A| and |B|, and latch the result sign: mult sign = A[31]^B[31]; quotient sign = A[31]^B[31]; remainder sign = A[31].
    - If Sign=0, use raw operands with sign flags 0.
    - Counter<=0; go to MUL or DIV; Busy<=1.
- MUL: radix-2 shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first. After ITER cycles go to FIX.
- DIV: restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits to absorb the trial-subtract borrow. After ITER cycles go to FIX.
- FIX (one cycle):
  - Apply two's-complement negation where the latched sign is set.
  - Write results: mult gives Hi = product[63:32], Lo = product[31:0]; div gives Lo = quotient, Hi = remainder.
  - Done<=1 for exactly one cycle; Busy<=0; state<=IDLE.
- Timing: Start sampled at edge E0 → Busy high from E0 through E0+33 → Hi/Lo/Done updated at edge E0+33. Total latency 33 cycles. Hi/Lo are stable and unchanged while Busy=1.
- Start while Busy=1 is ignored for every Op, including mthi/mtlo. Control must hold Start until Busy=0.
- A Start asserted in the same cycle that Done is high is accepted (state is IDLE). This allows back-to-back operations with no gap cycle.
- Divide by zero (B=0), either signedness: no trap, same 33-cycle latency, Lo=32'hFFFFFFFF, Hi=A as originally presented.
- Signed overflow: 0x80000000 / 0xFFFFFFFF (Sign=1) gives Lo=0x80000000, Hi=0. This is the natural magnitude-path result.
- Operands are latched at Start. Changes on A/B/Sign/Op during Busy have no effect.
- The unit has no Z/flag outputs; overflow on mult is impossible (full 64-bit product).

Decomposition:
- Shared package muldiv_pkg holds:
  - Op encodings: OP_MULT, OP_DIV, OP_MTHI, OP_MTLO.
  - State encoding: S_IDLE, S_MUL, S_DIV, S_FIX.
  - ITER localparam.
- One natural sub-module, muldiv_signfix: combinational conditional-negate/abs of a WIDTH-bit value. It is instantiated for operand abs at Start and for result fixup in FIX.
- The FSM and datapath stay in muldiv_unit.

Test Plan:
- Reset held low 3 cycles, then released → Busy=0, Done=0, Hi=Lo=0. Then assert reset low mid-MUL at cycle 10 → Hi/Lo=0 immediately, Busy=0; after release, no Done ever fires for the aborted op.
- Unsigned mult, A=B=0xFFFFFFFF, Sign=0 → Done exactly 33 cycles after Start, Hi=0xFFFFFFFE, Lo=0x00000001; Busy high for cycles 1..33.
- Signed mult A=0xFFFFFFFD (-3), B=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Then signed div A=0xFFFFFFF9 (-7), B=2 issued in the Done cycle → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, with Done 33 cycles later.
- Div by zero: A=0x12345678, B=0, Sign=0 → Lo=0xFFFFFFFF, Hi=0x12345678. Signed 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- mthi A=0xDEADBEEF, then mtlo A=0xCAFEF00D on the next edge → Hi/Lo updated one edge each, Busy/Done stay 0. mthi with Start pulsed during a Busy mult → ignored; Hi reflects only the mult result.
- A/B/Op/Sign randomized every cycle while Busy=1 → result matches values latched at Start (compare against 64-bit reference model over 1000 random signed/unsigned ops).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit.
//   XLEN  : default operand and HI/LO width
//   ITER  : iteration cycles per mult/div; must equal the unit's WIDTH
//   op_e  : Op encodings driven by control
//   state_e : unit FSM states
package muldiv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ITER = XLEN;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage bundle between control/register file and the multiply/divide unit.
//   A, B   : operands (rs, rt)       Sign  : 1 = signed operation
//   Op     : operation select        Start : request, taken only when Busy=0
//   Busy   : mult/div in flight      Done  : one-cycle pulse when HI/LO get new results
//   Hi, Lo : architectural HI/LO registers
interface muldiv_if #(
  parameter int unsigned WIDTH = muldiv_pkg::XLEN
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sign;
  logic [1:0]       Op;
  logic             Start;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output A, B, Sign, Op, Start,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  A, B, Sign, Op, Start,
    output Busy, Done, Hi, Lo
  );

endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// (neg = sign bit of a signed operand) and to restore result signs.
//   value  : input value
//   neg    : 1 = output -value, 0 = pass through
//   result : conditionally negated value
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// mult: radix-2 shift-add, LSB first. div: restoring, MSB first. Both run on
// magnitudes and fix the sign in a final cycle, giving a 33-cycle latency.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : muldiv_if slave (A, B, Sign, Op, Start in; Busy, Done, Hi, Lo out)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN  // ITER must equal WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int unsigned CntW = $clog2(ITER);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // mult: {product high, multiplier/product low}; div: low half holds dividend/quotient
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  // multiplicand for mult, divisor for div
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 is_div_q, is_div_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  op_e                  op;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic                 div_ge;

  assign op = op_e'(bus.Op);

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
    .value  (bus.A),
    .neg    (bus.Sign & bus.A[WIDTH-1]),
    .result (abs_a)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
    .value  (bus.B),
    .neg    (bus.Sign & bus.B[WIDTH-1]),
    .result (abs_b)
  );

  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value  (acc_q),
    .neg    (neg_lo_q),
    .result (prod_fix)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_quo (
    .value  (acc_q[WIDTH-1:0]),
    .neg    (neg_lo_q),
    .result (quo_fix)
  );

  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (
    .value  (rem_q),
    .neg    (neg_hi_q),
    .result (rem_fix)
  );

  // One shift-add step: carry out of the upper half shifts into the top bit.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};

  // One restoring step: the shifted partial remainder needs WIDTH+1 bits.
  assign div_trial = {rem_q, acc_q[WIDTH-1]};
  assign div_ge    = (div_trial >= {1'b0, opb_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          unique case (op)
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            OP_MULT: begin
              opb_d    = abs_a;
              acc_d    = {{WIDTH{1'b0}}, abs_b};
              neg_lo_d = bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              neg_hi_d = bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              is_div_d = 1'b0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            OP_DIV: begin
              opb_d    = abs_b;
              acc_d    = {{WIDTH{1'b0}}, abs_a};
              rem_d    = '0;
              // Divide by zero leaves the all-ones quotient unsigned-looking
              neg_lo_d = bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & (|bus.B);
              neg_hi_d = bus.Sign & bus.A[WIDTH-1];
              is_div_d = 1'b1;
              cnt_d    = '0;
              state_d  = S_DIV;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        rem_d = div_ge ? WIDTH'(div_trial - {1'b0, opb_q}) : div_trial[WIDTH-1:0];
        acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.Busy = (state_q != S_IDLE);
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// mult/div traffic against a plain-arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              sa, sb, q, r;
    logic [31:0]     uq, ur;
    if (op == OP_MULT) begin
      if (sgn) begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      up = longint'(a) * longint'(b);
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r, q};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // mode 0: quiet inputs while busy; 1: scramble all inputs every cycle;
  // 2: pulse an mthi Start mid-operation. b2b: issue in the current (Done) cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int mode, input bit b2b);
    int          cyc;
    int          busy_n;
    bit          seen;
    bit          stable;
    logic [31:0] hi0, lo0;
    if (!b2b) @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.Sign  = sgn;
    bus.A     = a;
    bus.B     = b;
    hi0       = bus.Hi;
    lo0       = bus.Lo;
    @(negedge clk);
    bus.Start = 1'b0;
    cyc    = 0;
    busy_n = 0;
    seen   = 1'b0;
    stable = 1'b1;
    while (cyc < 40 && !seen) begin
      if (bus.Done) begin
        seen = 1'b1;
      end else begin
        if (bus.Busy) busy_n++;
        if (bus.Hi !== hi0 || bus.Lo !== lo0) stable = 1'b0;
        if (mode == 1) begin
          bus.Start = 1'($urandom_range(0, 1));
          bus.Op    = 2'($urandom_range(0, 3));
          bus.Sign  = 1'($urandom_range(0, 1));
          bus.A     = $urandom;
          bus.B     = $urandom;
        end else if (mode == 2) begin
          bus.Start = (cyc == 5);
          bus.Op    = OP_MTHI;
          bus.A     = 32'hBAD0_BAD0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.Start = 1'b0;
    check_eq({tag, ".latency"}, 64'(cyc), 64'd33);
    check_eq({tag, ".busy_cycles"}, 64'(busy_n), 64'd33);
    check_eq({tag, ".busy_at_done"}, 64'(bus.Busy), 64'd0);
    check_eq({tag, ".hilo_stable"}, 64'(stable), 64'd1);
    check_eq({tag, ".hi"}, 64'(bus.Hi), 64'(exp_hi));
    check_eq({tag, ".lo"}, 64'(bus.Lo), 64'(exp_lo));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a, b;
    int          dones;

    reset     = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = OP_MULT;
    bus.Sign  = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("reset.busy", 64'(bus.Busy), 64'd0);
    check_eq("reset.done", 64'(bus.Done), 64'd0);
    check_eq("reset.hi", 64'(bus.Hi), 64'd0);
    check_eq("reset.lo", 64'(bus.Lo), 64'd0);

    run_op("umul_max", OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 0, 1'b0);
    run_op("smul_neg", OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 1'b0);
    run_op("sdiv_b2b", OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1'b1);
    run_op("udiv_zero", OP_DIV, 1'b0, 32'h1234_5678, 32'd0,
           32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("sdiv_ovf", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 0, 1'b0);

    // mthi then mtlo on consecutive edges
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = OP_MTHI;
    bus.A     = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("mthi.hi", 64'(bus.Hi), 64'h0000_0000_DEAD_BEEF);
    check_eq("mthi.busy", 64'(bus.Busy), 64'd0);
    check_eq("mthi.done", 64'(bus.Done), 64'd0);
    bus.Op = OP_MTLO;
    bus.A  = 32'hCAFE_F00D;
    @(negedge clk);
    bus.Start = 1'b0;
    check_eq("mtlo.lo", 64'(bus.Lo), 64'h0000_0000_CAFE_F00D);
    check_eq("mtlo.hi", 64'(bus.Hi), 64'h0000_0000_DEAD_BEEF);
    check_eq("mtlo.busy", 64'(bus.Busy), 64'd0);
    check_eq("mtlo.done", 64'(bus.Done), 64'd0);

    run_op("mthi_ignored", OP_MULT, 1'b0, 32'd7, 32'd9, 32'd0, 32'd63, 2, 1'b0);

    // Reset mid-MUL: HI/LO clear at once, aborted op never completes
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Op    = OP_MTHI;
    bus.A     = 32'h5555_AAAA;
    @(negedge clk);
    bus.Op = OP_MULT;
    bus.A  = 32'hFFFF_FFFF;
    bus.B  = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_mid.hi", 64'(bus.Hi), 64'd0);
    check_eq("rst_mid.lo", 64'(bus.Lo), 64'd0);
    check_eq("rst_mid.busy", 64'(bus.Busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    check_eq("rst_mid.no_done", 64'(dones), 64'd0);
    check_eq("rst_mid.idle", 64'(bus.Busy), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      op  = 2'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_model(op, sgn, a, b);
      run_op($sformatf("rand%0d", i), op, sgn, a, b, exp[63:32], exp[31:0], 1,
             ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
